// File: rtl/alu_pkg.sv
// Shared ALU definitions: data/opcode widths, opcode encodings, command
// payload layout and the legal-opcode check used by ALU-side blocks.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_AND  = 4'd2;
  localparam logic [OP_W-1:0] OP_OR   = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
  localparam logic [OP_W-1:0] OP_NOT  = 4'd5;
  localparam logic [OP_W-1:0] OP_EQ   = 4'd6;
  localparam logic [OP_W-1:0] OP_LT   = 4'd7;
  localparam logic [OP_W-1:0] OP_GT   = 4'd8;
  localparam logic [OP_W-1:0] OP_LAST = 4'd8;

  // ALU command payload without the tag (tag width is a block parameter)
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] a;
  } alu_cmd_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return (op <= OP_LAST);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Generic synchronous FIFO with async active-low reset.
// Ports: clk, rst_n; i_push/i_wdata write side (ignored when full);
// i_pop pops the head (ignored when empty); o_head is the current head
// entry; o_full/o_empty/o_count report occupancy.
module alu_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_pop,
  output logic [W-1:0]             o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Storage needs no reset; only pointers/count define validity
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator-side front end for the combinational ALU: buffers tagged
// commands, drives the ALU from the FIFO head, registers one response and
// returns responses in order; counts overflow responses (saturating).
// Ports: clk, rst_n; cmd_* request channel (valid/ready); alu_* ALU drive
// and combinational return; rsp_* response channel (valid/ready);
// ovf_count overflow-event counter; busy = work queued or response pending.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned OVF_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [DATA_W-1:0]    cmd_a,
  input  logic [DATA_W-1:0]    cmd_b,
  input  logic [OP_W-1:0]      cmd_op,
  input  logic [TAG_W-1:0]     cmd_tag,
  output logic [DATA_W-1:0]    alu_a,
  output logic [DATA_W-1:0]    alu_b,
  output logic [OP_W-1:0]      alu_op,
  input  logic [DATA_W-1:0]    alu_result,
  input  logic                 alu_zero,
  input  logic                 alu_overflow,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_result,
  output logic                 rsp_zero,
  output logic                 rsp_overflow,
  output logic                 rsp_err,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic [OVF_CNT_W-1:0] ovf_count,
  output logic                 busy
);

  localparam int unsigned CMD_W  = $bits(alu_cmd_t);
  localparam int unsigned FIFO_W = TAG_W + CMD_W;
  localparam int unsigned CW     = $clog2(DEPTH) + 1;

  alu_cmd_t             w_cmd_in;
  alu_cmd_t             w_head_cmd;
  logic [TAG_W-1:0]     w_head_tag;
  logic [FIFO_W-1:0]    w_head;
  logic                 w_full;
  logic                 w_empty;
  logic [CW-1:0]        w_count;
  logic                 w_push;
  logic                 w_fire;
  logic                 w_legal;

  logic                 r_rsp_valid;
  logic [DATA_W-1:0]    r_rsp_result;
  logic                 r_rsp_zero;
  logic                 r_rsp_overflow;
  logic                 r_rsp_err;
  logic [TAG_W-1:0]     r_rsp_tag;
  logic [OVF_CNT_W-1:0] r_ovf_count;

  assign w_cmd_in = '{op: cmd_op, b: cmd_b, a: cmd_a};
  assign w_push   = cmd_valid && !w_full;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata ({cmd_tag, w_cmd_in}),
    .i_pop   (w_fire),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_head_tag = w_head[FIFO_W-1 -: TAG_W];
  assign w_head_cmd = alu_cmd_t'(w_head[CMD_W-1:0]);
  assign w_legal    = is_legal_op(w_head_cmd.op);

  // Ready reflects occupancy only: a full FIFO never accepts, even on a pop
  assign cmd_ready = (w_count != CW'(DEPTH));

  // Head issues when the response register is free or being drained
  assign w_fire = !w_empty && (!r_rsp_valid || rsp_ready);

  // ALU operands idle at zero when nothing is queued
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    if (!w_empty) begin
      alu_a  = w_head_cmd.a;
      alu_b  = w_head_cmd.b;
      alu_op = w_head_cmd.op;
    end
  end

  // Response register; illegal opcodes ignore the ALU and report an error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid    <= 1'b0;
      r_rsp_result   <= '0;
      r_rsp_zero     <= 1'b0;
      r_rsp_overflow <= 1'b0;
      r_rsp_err      <= 1'b0;
      r_rsp_tag      <= '0;
    end else if (w_fire) begin
      r_rsp_valid    <= 1'b1;
      r_rsp_tag      <= w_head_tag;
      r_rsp_result   <= w_legal ? alu_result : '0;
      r_rsp_zero     <= w_legal ? alu_zero : 1'b1;
      r_rsp_overflow <= w_legal ? alu_overflow : 1'b0;
      r_rsp_err      <= !w_legal;
    end else if (rsp_ready) begin
      r_rsp_valid    <= 1'b0;
    end
  end

  // Saturating count of responses loaded with overflow set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_count <= '0;
    end else if (w_fire && w_legal && alu_overflow && (r_ovf_count != '1)) begin
      r_ovf_count <= r_ovf_count + OVF_CNT_W'(1);
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_result   = r_rsp_result;
  assign rsp_zero     = r_rsp_zero;
  assign rsp_overflow = r_rsp_overflow;
  assign rsp_err      = r_rsp_err;
  assign rsp_tag      = r_rsp_tag;
  assign ovf_count    = r_ovf_count;
  assign busy         = !w_empty || r_rsp_valid;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: a behavioural ALU drives the
// DUT's ALU inputs, a queue-based reference predicts every output each
// cycle, and directed scenarios pin literal results.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned TAG_W     = 4;
  localparam int unsigned OVF_CNT_W = 16;

  logic                 clk;
  logic                 rst_n;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [31:0]          cmd_a;
  logic [31:0]          cmd_b;
  logic [3:0]           cmd_op;
  logic [TAG_W-1:0]     cmd_tag;
  logic [31:0]          alu_a;
  logic [31:0]          alu_b;
  logic [3:0]           alu_op;
  logic [31:0]          alu_result;
  logic                 alu_zero;
  logic                 alu_overflow;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_result;
  logic                 rsp_zero;
  logic                 rsp_overflow;
  logic                 rsp_err;
  logic [TAG_W-1:0]     rsp_tag;
  logic [OVF_CNT_W-1:0] ovf_count;
  logic                 busy;

  alu_cmd_sequencer #(
    .DEPTH     (DEPTH),
    .TAG_W     (TAG_W),
    .OVF_CNT_W (OVF_CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .cmd_op       (cmd_op),
    .cmd_tag      (cmd_tag),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow),
    .rsp_err      (rsp_err),
    .rsp_tag      (rsp_tag),
    .ovf_count    (ovf_count),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic        ovf;
    logic        zero;
    logic [31:0] res;
  } rsp_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [3:0]       op;
    logic [31:0]      b;
    logic [31:0]      a;
  } mcmd_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected response for a command (illegal ops: err, result 0, zero 1)
  function automatic rsp_t ref_alu(input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] op);
    rsp_t        r;
    logic [32:0] s;
    r = '0;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; r.res = s[31:0]; r.ovf = s[32]; end
      4'd1: begin r.res = a - b; r.ovf = (a < b); end
      4'd2: r.res = a & b;
      4'd3: r.res = a | b;
      4'd4: r.res = a ^ b;
      4'd5: r.res = ~a;
      4'd6: r.res = (a == b) ? 32'd1 : 32'd0;
      4'd7: r.res = (a < b)  ? 32'd1 : 32'd0;
      4'd8: r.res = (a > b)  ? 32'd1 : 32'd0;
      default: r.err = 1'b1;
    endcase
    r.zero = (r.res == 32'd0);
    return r;
  endfunction

  // Behavioural ALU; emits junk on illegal opcodes so ignoring it is observable
  rsp_t alu_r;
  always_comb begin
    alu_r        = ref_alu(alu_a, alu_b, alu_op);
    alu_result   = alu_r.res;
    alu_zero     = alu_r.zero;
    alu_overflow = alu_r.ovf;
    if (alu_r.err) begin
      alu_result   = 32'hDEADBEEF;
      alu_zero     = 1'b0;
      alu_overflow = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted commands in a queue plus one response slot
  mcmd_t       mq[$];
  bit          m_valid;
  rsp_t        m_rsp;
  logic [3:0]  m_tag;
  int          m_cnt;
  bit          m_fire;
  bit          m_push;
  mcmd_t       m_h;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_valid = 1'b0;
      m_rsp   = '0;
      m_tag   = '0;
      m_cnt   = 0;
    end else begin
      m_fire = (mq.size() > 0) && (!m_valid || rsp_ready);
      m_push = cmd_valid && (mq.size() != DEPTH);
      if (m_fire) begin
        m_h     = mq.pop_front();
        m_rsp   = ref_alu(m_h.a, m_h.b, m_h.op);
        m_tag   = m_h.tag;
        m_valid = 1'b1;
        if (m_rsp.ovf && m_cnt < 65535) m_cnt++;
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
      if (m_push) mq.push_back('{tag: cmd_tag, op: cmd_op, b: cmd_b, a: cmd_a});
    end
  end

  // Per-cycle compare on the falling edge, plus delivered-tag log
  logic [3:0] dq[$];
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmd_ready", 64'(cmd_ready), 64'(mq.size() != DEPTH));
      chk("busy", 64'(busy), 64'((mq.size() > 0) || m_valid));
      chk("alu_a", 64'(alu_a), 64'((mq.size() > 0) ? mq[0].a : 32'd0));
      chk("alu_b", 64'(alu_b), 64'((mq.size() > 0) ? mq[0].b : 32'd0));
      chk("alu_op", 64'(alu_op), 64'((mq.size() > 0) ? mq[0].op : 4'd0));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
      chk("rsp_result", 64'(rsp_result), 64'(m_rsp.res));
      chk("rsp_zero", 64'(rsp_zero), 64'(m_rsp.zero));
      chk("rsp_overflow", 64'(rsp_overflow), 64'(m_rsp.ovf));
      chk("rsp_err", 64'(rsp_err), 64'(m_rsp.err));
      chk("rsp_tag", 64'(rsp_tag), 64'(m_tag));
      chk("ovf_count", 64'(ovf_count), 64'(m_cnt));
      if (rsp_valid && rsp_ready) dq.push_back(rsp_tag);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a command until accepted (bounded)
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op, input logic [3:0] tag);
    bit acc;
    bit done;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag; cmd_valid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      acc = cmd_ready;
      step();
      if (acc) done = 1'b1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: tag %0d not accepted, required acceptance", tag);
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
    cmd_tag = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ovf_count", 64'(ovf_count), 64'd0);
    chk("reset_rsp_zero", 64'(rsp_zero), 64'd0);
    rst_n = 1'b1;
    step();

    // ADD carry-out to zero
    rsp_ready = 1'b1;
    send(32'hFFFFFFFF, 32'h1, OP_ADD, 4'd3);
    cmd_valid = 1'b0;
    step();
    chk("add_valid", 64'(rsp_valid), 64'd1);
    chk("add_result", 64'(rsp_result), 64'd0);
    chk("add_zero", 64'(rsp_zero), 64'd1);
    chk("add_ovf", 64'(rsp_overflow), 64'd1);
    chk("add_err", 64'(rsp_err), 64'd0);
    chk("add_tag", 64'(rsp_tag), 64'd3);
    chk("add_ovf_count", 64'(ovf_count), 64'd1);
    step();

    // SUB borrow, then AND back-to-back
    send(32'd5, 32'd7, OP_SUB, 4'd1);
    send(32'hF0F0F0F0, 32'h0F0F0F0F, OP_AND, 4'd2);
    chk("sub_result", 64'(rsp_result), 64'hFFFFFFFE);
    chk("sub_ovf", 64'(rsp_overflow), 64'd1);
    chk("sub_tag", 64'(rsp_tag), 64'd1);
    cmd_valid = 1'b0;
    step();
    chk("and_valid", 64'(rsp_valid), 64'd1);
    chk("and_result", 64'(rsp_result), 64'd0);
    chk("and_zero", 64'(rsp_zero), 64'd1);
    chk("and_ovf", 64'(rsp_overflow), 64'd0);
    chk("and_tag", 64'(rsp_tag), 64'd2);
    chk("and_ovf_count", 64'(ovf_count), 64'd2);
    step();

    // Backpressure: DEPTH+1 held, sixth refused until drain starts
    rsp_ready = 1'b0;
    for (int t = 0; t < 5; t++) send(32'(t), 32'd1, OP_ADD, 4'(t));
    cmd_a = 32'd5; cmd_b = 32'd1; cmd_op = OP_ADD; cmd_tag = 4'd5; cmd_valid = 1'b1;
    step();
    chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("bp_head_tag", 64'(rsp_tag), 64'd0);
    dq.delete();
    rsp_ready = 1'b1;
    send(32'd5, 32'd1, OP_ADD, 4'd5);
    cmd_valid = 1'b0;
    repeat (10) step();
    chk("bp_count", 64'(dq.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      logic [3:0] got;
      got = (i < dq.size()) ? dq[i] : 4'hX;
      chk("bp_order", 64'(got), 64'(i));
    end

    // Illegal opcode ignores the ALU
    send(32'd1, 32'd1, 4'hF, 4'd7);
    cmd_valid = 1'b0;
    step();
    chk("ill_err", 64'(rsp_err), 64'd1);
    chk("ill_result", 64'(rsp_result), 64'd0);
    chk("ill_zero", 64'(rsp_zero), 64'd1);
    chk("ill_ovf", 64'(rsp_overflow), 64'd0);
    chk("ill_tag", 64'(rsp_tag), 64'd7);
    chk("ill_ovf_count", 64'(ovf_count), 64'd2);
    step();

    // Compare ops with a=2 b=9
    send(32'd2, 32'd9, OP_EQ, 4'd8);
    send(32'd2, 32'd9, OP_LT, 4'd9);
    chk("eq_result", 64'(rsp_result), 64'd0);
    chk("eq_zero", 64'(rsp_zero), 64'd1);
    send(32'd2, 32'd9, OP_GT, 4'd10);
    chk("lt_result", 64'(rsp_result), 64'd1);
    chk("lt_zero", 64'(rsp_zero), 64'd0);
    cmd_valid = 1'b0;
    step();
    chk("gt_result", 64'(rsp_result), 64'd0);
    chk("gt_zero", 64'(rsp_zero), 64'd1);
    step();

    // Reset with one pending response and three queued commands
    rsp_ready = 1'b0;
    for (int t = 0; t < 4; t++) send(32'hFFFFFFFF, 32'd1, OP_ADD, 4'(11 + t));
    cmd_valid = 1'b0;
    chk("pre_rst_valid", 64'(rsp_valid), 64'd1);
    chk("pre_rst_ovf_count", 64'(ovf_count), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_ovf_count", 64'(ovf_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("no_stale", 64'(rsp_valid), 64'd0);
    end

    // Randomized traffic with phases of varying backpressure
    for (int c = 0; c < 3000; c++) begin
      int ph;
      ph = c / 500;
      cmd_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = (ph % 2 == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
      cmd_op    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15))
                                              : 4'($urandom_range(0, 8));
      cmd_a     = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      cmd_b     = ($urandom_range(0, 3) == 0) ? cmd_a : $urandom;
      cmd_tag   = 4'($urandom);
      step();
    end

    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (10) step();
    chk("drain_busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Initiator-side front end for the 32-bit combinational ALU. It accepts tagged ALU commands on a valid/ready request channel and buffers them in a small FIFO. It drives the ALU operand/opcode inputs from the FIFO head, captures result/zero/overflow into a response register, and returns tagged responses in order on a valid/ready response channel. It also keeps a saturating count of overflow events for status readout.

Parameters:
DEPTH, 4, command FIFO entries; power of two, >=2
TAG_W, 4, width of the opaque command tag echoed in the response
OVF_CNT_W, 16, width of the saturating overflow-event counter

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  command FIFO can accept (= not full)
cmd_a  input  32  operand A
cmd_b  input  32  operand B
cmd_op  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 EQ, 7 LT, 8 GT; 9-15 illegal
cmd_tag  input  TAG_W  opaque tag
alu_a  output  32  to ALU operand A
alu_b  output  32  to ALU operand B
alu_op  output  4  to ALU opcode
alu_result  input  32  from ALU, same-cycle combinational
alu_zero  input  1  from ALU
alu_overflow  input  1  from ALU (carry-out for ADD, borrow for SUB, 0 otherwise)
rsp_valid  output  1  response register holds a response
rsp_ready  input  1  consumer accepts response
rsp_result  output  32  captured result
rsp_zero  output  1  captured zero flag
rsp_overflow  output  1  captured overflow flag
rsp_err  output  1  1 = illegal opcode; ALU output was ignored
rsp_tag  output  TAG_W  tag of the command
ovf_count  output  OVF_CNT_W  saturating count of responses with rsp_overflow=1
busy  output  1  FIFO non-empty or rsp_valid

Behaviour:
- Reset (async assert, sync release): FIFO empty, rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_overflow=0, rsp_err=0, rsp_tag=0, ovf_count=0. Therefore cmd_ready=1 and busy=0.
- Push: when cmd_valid && cmd_ready, the command is written at the edge. cmd_ready = (count != DEPTH). It does not depend on same-cycle pop, so there is no full-FIFO bypass.
- ALU drive: when the FIFO is non-empty, alu_a/alu_b/alu_op are driven combinationally from the FIFO head. When it is empty, they are driven to 0/0/4'b0000.
- Issue condition: fire = FIFO non-empty && (!rsp_valid || rsp_ready).
  - On fire, the head is popped and the response register loads at the same edge.
- Legal op load: rsp_result=alu_result, rsp_zero=alu_zero, rsp_overflow=alu_overflow, rsp_err=0, rsp_tag=head tag.
- Illegal op (9-15) load: rsp_result=0, rsp_zero=1, rsp_overflow=0, rsp_err=1, tag echoed.
- rsp_valid update: set on fire. Cleared on rsp_ready && !fire. Held otherwise. Response fields are stable while rsp_valid && !rsp_ready.
- Latency: a command accepted at edge N into an empty FIFO with the response register free gives rsp_valid=1 after edge N+1. Sustained throughput is 1 response/cycle with rsp_ready held high.
- Capacity: with rsp_ready=0, DEPTH+1 commands are held (1 in the response register, DEPTH in the FIFO).
- Ordering: strictly FIFO; tags return in acceptance order.
- Simultaneous push and pop on the same edge: count unchanged, both take effect. Pointers wrap modulo DEPTH.
- ovf_count: increments on each fire loading rsp_overflow=1 and saturates at all-ones.
- Reset mid-operation: all queued and pending responses are discarded with no response emitted, and all outputs return to their reset values immediately.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_ADD..OP_GT
  - OP_LAST=4'd8
  - DATA_W=32, OP_W=4
  - function is_legal_op
- Sub-module alu_cmd_fifo: parameterised synchronous FIFO with async active-low reset. It carries {tag, op, b, a}, exposes head data, full, empty and count, and is reused by later ALU-side blocks.

Test Plan:
- Reset, then ADD a=0xFFFFFFFF b=0x1 tag=3, rsp_ready=1 -> one cycle after accept: rsp_result=0, zero=1, overflow=1, err=0, tag=3; ovf_count=1.
- SUB a=5 b=7, then AND a=0xF0F0F0F0 b=0x0F0F0F0F back-to-back -> SUB returns 0xFFFFFFFE, overflow=1. AND follows the next cycle with result 0, zero=1, overflow=0.
- Backpressure with DEPTH=4, rsp_ready=0, 6 commands offered (tags 0-5) -> cmd_ready drops after 5 accepts. Releasing rsp_ready returns tags 0-4 in order, one per cycle, then tag 5 after it is accepted.
- Illegal op 4'hF with a=1 b=1 -> rsp_err=1, result=0, zero=1, overflow=0; ovf_count unchanged.
- Opcodes EQ/LT/GT with a=2 b=9 -> results 0, 1, 0 respectively; zero=1, 0, 1.
- Assert rst_n low with 3 commands queued and rsp_valid=1 -> rsp_valid=0 and ovf_count=0 immediately, cmd_ready=1 after release, no stale response appears afterwards.
